// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target for 16-bit-address/16-bit-word register access, oversampled on clk
// Filtered SCL/SDA drive a byte-level FSM that bridges bus transfers onto a strobe-based register port.

module i2c_target #(
   parameter logic [6:0] ADDRESS    = 7'h33,
   parameter int         FILTER_LEN = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_out,
   output logic        sda_oe,
   output logic [15:0] reg_addr,
   output logic        reg_rd_strobe,
   input  logic [15:0] reg_rd_data,
   output logic        reg_wr_strobe,
   output logic [15:0] reg_wr_data,
   output logic        busy
);

   localparam int CW = $clog2(FILTER_LEN + 1);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, IGNORE
   } state_t;

   state_t        state_q, state_d;
   logic [1:0]    scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
   logic [CW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
   logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
   logic          scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
   logic [3:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d, tx_sh_q, tx_sh_d, data_hi_q, data_hi_d;
   logic [15:0]   tx_word_q, tx_word_d, reg_addr_q, reg_addr_d, reg_wr_data_q, reg_wr_data_d;
   logic [1:0]    byte_idx_q, byte_idx_d;
   logic          tx_lo_q, tx_lo_d, rw_q, rw_d;
   logic          rd_strobe_q, rd_strobe_d, wr_strobe_q, wr_strobe_d;
   logic          rd_pending_q, rd_pending_d, busy_q, busy_d, sda_oe_q, sda_oe_d;

   logic       scl_rise, scl_fall, start_evt, stop_evt, addr_match, byte_done;
   logic [7:0] tx_next_byte;

   assign scl_rise     = scl_f_q & ~scl_prev_q;
   assign scl_fall     = ~scl_f_q & scl_prev_q;
   assign start_evt    = scl_f_q & scl_prev_q & sda_prev_q & ~sda_f_q;
   assign stop_evt     = scl_f_q & scl_prev_q & ~sda_prev_q & sda_f_q;
   assign addr_match   = (shift_q[7:1] == ADDRESS);
   assign byte_done    = scl_fall && (bit_cnt_q == 4'd8);
   assign tx_next_byte = tx_lo_q ? tx_word_q[7:0] : tx_word_q[15:8];

   assign sda_out       = 1'b0;
   assign sda_oe        = sda_oe_q;
   assign reg_addr      = reg_addr_q;
   assign reg_rd_strobe = rd_strobe_q;
   assign reg_wr_strobe = wr_strobe_q;
   assign reg_wr_data   = reg_wr_data_q;
   assign busy          = busy_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         scl_sync_q    <= 2'b11;
         sda_sync_q    <= 2'b11;
         scl_cnt_q     <= '0;
         sda_cnt_q     <= '0;
         scl_f_q       <= 1'b1;
         sda_f_q       <= 1'b1;
         scl_prev_q    <= 1'b1;
         sda_prev_q    <= 1'b1;
         bit_cnt_q     <= 4'd0;
         shift_q       <= 8'd0;
         tx_sh_q       <= 8'd0;
         data_hi_q     <= 8'd0;
         tx_word_q     <= 16'd0;
         reg_addr_q    <= 16'd0;
         reg_wr_data_q <= 16'd0;
         byte_idx_q    <= 2'd0;
         tx_lo_q       <= 1'b0;
         rw_q          <= 1'b0;
         rd_strobe_q   <= 1'b0;
         wr_strobe_q   <= 1'b0;
         rd_pending_q  <= 1'b0;
         busy_q        <= 1'b0;
         sda_oe_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         scl_sync_q    <= scl_sync_d;
         sda_sync_q    <= sda_sync_d;
         scl_cnt_q     <= scl_cnt_d;
         sda_cnt_q     <= sda_cnt_d;
         scl_f_q       <= scl_f_d;
         sda_f_q       <= sda_f_d;
         scl_prev_q    <= scl_prev_d;
         sda_prev_q    <= sda_prev_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         tx_sh_q       <= tx_sh_d;
         data_hi_q     <= data_hi_d;
         tx_word_q     <= tx_word_d;
         reg_addr_q    <= reg_addr_d;
         reg_wr_data_q <= reg_wr_data_d;
         byte_idx_q    <= byte_idx_d;
         tx_lo_q       <= tx_lo_d;
         rw_q          <= rw_d;
         rd_strobe_q   <= rd_strobe_d;
         wr_strobe_q   <= wr_strobe_d;
         rd_pending_q  <= rd_pending_d;
         busy_q        <= busy_d;
         sda_oe_q      <= sda_oe_d;
      end
   end

   // A filtered level flips only after FILTER_LEN consecutive disagreeing samples.
   always_comb begin
      scl_sync_d = {scl_sync_q[0], scl_in};
      sda_sync_d = {sda_sync_q[0], sda_in};
      scl_prev_d = scl_f_q;
      sda_prev_d = sda_f_q;
      scl_f_d    = scl_f_q;
      sda_f_d    = sda_f_q;
      scl_cnt_d  = '0;
      sda_cnt_d  = '0;
      if (scl_sync_q[1] != scl_f_q) begin
         if (scl_cnt_q == CW'(FILTER_LEN - 1)) scl_f_d = scl_sync_q[1];
         else scl_cnt_d = scl_cnt_q + 1'b1;
      end
      if (sda_sync_q[1] != sda_f_q) begin
         if (sda_cnt_q == CW'(FILTER_LEN - 1)) sda_f_d = sda_sync_q[1];
         else sda_cnt_d = sda_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      if (start_evt) state_d = ADDR;
      else if (stop_evt) state_d = IDLE;
      else begin
         case (state_q)
            ADDR:     if (byte_done) state_d = addr_match ? ADDR_ACK : IGNORE;
            ADDR_ACK: if (scl_fall) state_d = rw_q ? TX_BYTE : RX_BYTE;
            RX_BYTE:  if (byte_done) state_d = RX_ACK;
            RX_ACK:   if (scl_fall) state_d = RX_BYTE;
            TX_BYTE:  if (byte_done) state_d = TX_ACK;
            TX_ACK: begin
               if (scl_rise && sda_f_q) state_d = IGNORE;
               else if (scl_fall) state_d = TX_BYTE;
            end
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      tx_sh_d       = tx_sh_q;
      data_hi_d     = data_hi_q;
      tx_word_d     = rd_pending_q ? reg_rd_data : tx_word_q;
      reg_addr_d    = wr_strobe_q ? reg_addr_q + 16'd1 : reg_addr_q;
      reg_wr_data_d = reg_wr_data_q;
      byte_idx_d    = byte_idx_q;
      tx_lo_d       = tx_lo_q;
      rw_d          = rw_q;
      rd_strobe_d   = 1'b0;
      wr_strobe_d   = 1'b0;
      rd_pending_d  = rd_strobe_q;
      busy_d        = busy_q;
      sda_oe_d      = sda_oe_q;
      if (start_evt) begin
         bit_cnt_d = 4'd0;
         sda_oe_d  = 1'b0;
         busy_d    = 1'b0;
      end else if (stop_evt) begin
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ADDR, RX_BYTE: begin
               if (scl_rise) begin
                  shift_d   = {shift_q[6:0], sda_f_q};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (byte_done && state_q == ADDR) begin
                  if (addr_match) begin
                     sda_oe_d    = 1'b1;
                     busy_d      = 1'b1;
                     rw_d        = shift_q[0];
                     rd_strobe_d = shift_q[0];
                     tx_lo_d     = 1'b0;
                  end
               end else if (byte_done) begin
                  sda_oe_d = 1'b1;
                  case (byte_idx_q)
                     2'd0: begin reg_addr_d[15:8] = shift_q; byte_idx_d = 2'd1; end
                     2'd1: begin reg_addr_d[7:0]  = shift_q; byte_idx_d = 2'd2; end
                     2'd2: begin data_hi_d        = shift_q; byte_idx_d = 2'd3; end
                     default: begin
                        wr_strobe_d   = 1'b1;
                        reg_wr_data_d = {data_hi_q, shift_q};
                        byte_idx_d    = 2'd2;
                     end
                  endcase
               end
            end
            ADDR_ACK: if (scl_fall) begin
               bit_cnt_d  = 4'd0;
               byte_idx_d = 2'd0;
               sda_oe_d   = rw_q ? ~tx_next_byte[7] : 1'b0;
               tx_sh_d    = {tx_next_byte[6:0], 1'b0};
            end
            RX_ACK: if (scl_fall) begin
               bit_cnt_d = 4'd0;
               sda_oe_d  = 1'b0;
            end
            TX_BYTE: begin
               if (scl_rise) bit_cnt_d = bit_cnt_q + 4'd1;
               else if (byte_done) sda_oe_d = 1'b0;
               else if (scl_fall) begin
                  sda_oe_d = ~tx_sh_q[7];
                  tx_sh_d  = {tx_sh_q[6:0], 1'b0};
               end
            end
            TX_ACK: begin
               // Low-byte ACK advances the pointer and prefetches the next word.
               if (scl_rise) begin
                  if (sda_f_q) busy_d = 1'b0;
                  else if (tx_lo_q) begin
                     tx_lo_d     = 1'b0;
                     reg_addr_d  = reg_addr_q + 16'd1;
                     rd_strobe_d = 1'b1;
                  end else tx_lo_d = 1'b1;
               end else if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  sda_oe_d  = ~tx_next_byte[7];
                  tx_sh_d   = {tx_next_byte[6:0], 1'b0};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - scoreboard bench for i2c_target driving I2C initiator transfers
// Stimulus pushes expectations; a negedge monitor compares strobes, bus bytes and probes.

module tb_i2c_target;

   localparam int Q = 10;

   typedef struct {
      int          sel;
      logic [31:0] exp;
   } probe_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scl_drv = 1'b1;
   logic        sda_drv = 1'b1;
   logic        scl_in, sda_in, sda_out, sda_oe;
   logic [15:0] reg_addr, reg_wr_data;
   logic [15:0] rd_data = 16'd0;
   logic        reg_rd_strobe, reg_wr_strobe, busy;
   logic        quiet = 1'b0;

   logic [15:0] exp_rd[$];
   logic [31:0] exp_wr[$];
   int          exp_bus[$];
   int          obs_bus[$];
   probe_t      probe_q[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          quiet_viol = 0;

   int          mon_o, mon_e;
   logic [31:0] mon_act, mon_w;
   logic [15:0] mon_a;
   probe_t      mon_p;

   assign scl_in = scl_drv;
   assign sda_in = sda_drv & ~sda_oe;

   always #5 clk = ~clk;

   i2c_target dut (
      .clk           (clk),
      .reset         (reset),
      .scl_in        (scl_in),
      .sda_in        (sda_in),
      .sda_out       (sda_out),
      .sda_oe        (sda_oe),
      .reg_addr      (reg_addr),
      .reg_rd_strobe (reg_rd_strobe),
      .reg_rd_data   (rd_data),
      .reg_wr_strobe (reg_wr_strobe),
      .reg_wr_data   (reg_wr_data),
      .busy          (busy)
   );

   function automatic logic [15:0] mem_word(input logic [15:0] a);
      case (a)
         16'h2400: return 16'h1234;
         16'h2401: return 16'hABCD;
         16'hFFFF: return 16'hBEEF;
         16'h0000: return 16'h5A5A;
         16'h0010: return 16'h0F0F;
         default:  return a ^ 16'hC3C3;
      endcase
   endfunction

   always @(posedge clk) if (reg_rd_strobe) rd_data <= mem_word(reg_addr);

   function automatic logic [31:0] probe_val(input int sel);
      case (sel)
         0: return {31'd0, sda_oe};
         1: return {31'd0, busy};
         2: return {16'd0, reg_addr};
         3: return {31'd0, reg_rd_strobe};
         4: return {31'd0, reg_wr_strobe};
         5: return {31'd0, sda_out};
         6: return {16'd0, reg_wr_data};
         7: return quiet_viol;
         default: return exp_rd.size() + exp_wr.size() + exp_bus.size();
      endcase
   endfunction

   function automatic string probe_name(input int sel);
      case (sel)
         0: return "sda_oe";
         1: return "busy";
         2: return "reg_addr";
         3: return "reg_rd_strobe";
         4: return "reg_wr_strobe";
         5: return "sda_out";
         6: return "reg_wr_data";
         7: return "quiet_violations";
         default: return "pending_expectations";
      endcase
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         if (reg_rd_strobe && reg_wr_strobe) begin
            n_vec++; n_err++;
            $display("FAIL strobe_overlap: got rd=1 wr=1, expected at most one");
         end
         if (reg_rd_strobe) begin
            n_vec++;
            if (exp_rd.size() == 0) begin
               n_err++;
               $display("FAIL rd_strobe: got strobe at %h, expected none", reg_addr);
            end else begin
               mon_a = exp_rd.pop_front();
               if (reg_addr !== mon_a) begin
                  n_err++;
                  $display("FAIL rd_strobe_addr: got %h, expected %h", reg_addr, mon_a);
               end
            end
         end
         if (reg_wr_strobe) begin
            n_vec++;
            if (exp_wr.size() == 0) begin
               n_err++;
               $display("FAIL wr_strobe: got %h<=%h, expected none", reg_addr, reg_wr_data);
            end else begin
               mon_w = exp_wr.pop_front();
               if ({reg_addr, reg_wr_data} !== mon_w) begin
                  n_err++;
                  $display("FAIL wr_strobe_addr_data: got %h, expected %h", {reg_addr, reg_wr_data}, mon_w);
               end
            end
         end
      end
      if (quiet && (sda_oe || busy || reg_rd_strobe || reg_wr_strobe)) quiet_viol++;
      while (obs_bus.size() > 0) begin
         mon_o = obs_bus.pop_front();
         n_vec++;
         if (exp_bus.size() == 0) begin
            n_err++;
            $display("FAIL bus: got %h, expected nothing", mon_o);
         end else begin
            mon_e = exp_bus.pop_front();
            if (mon_o != mon_e) begin
               n_err++;
               $display("FAIL %s: got %h, expected %h", (mon_e >= 'h100) ? "bus_ack" : "bus_rdbyte", mon_o, mon_e);
            end
         end
      end
      while (probe_q.size() > 0) begin
         mon_p   = probe_q.pop_front();
         mon_act = probe_val(mon_p.sel);
         n_vec++;
         if (mon_act !== mon_p.exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", probe_name(mon_p.sel), mon_act, mon_p.exp);
         end
      end
   end

   task automatic q();
      repeat (Q) @(negedge clk);
   endtask

   task automatic probe(input int sel, input logic [31:0] e);
      probe_t p;
      @(posedge clk);
      #1;
      p.sel = sel;
      p.exp = e;
      probe_q.push_back(p);
   endtask

   task automatic i2c_start();
      if (!scl_drv) begin
         sda_drv = 1'b1; q();
         scl_drv = 1'b1; q();
      end
      sda_drv = 1'b0; q();
      scl_drv = 1'b0; q();
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; q();
      scl_drv = 1'b1; q();
      sda_drv = 1'b1; q();
   endtask

   task automatic wbit(input logic b, input logic glitch);
      sda_drv = b; q();
      scl_drv = 1'b1;
      if (glitch) begin
         repeat (6) @(negedge clk);
         scl_drv = 1'b0;
         repeat (2) @(negedge clk);
         scl_drv = 1'b1;
         repeat (2 * Q - 8) @(negedge clk);
      end else begin
         q(); q();
      end
      scl_drv = 1'b0; q();
   endtask

   task automatic rbit(output logic b);
      sda_drv = 1'b1; q();
      scl_drv = 1'b1; q();
      b = sda_in; q();
      scl_drv = 1'b0; q();
   endtask

   task automatic wbyte(input logic [7:0] d, input logic exp_ack, input int gbit);
      logic b;
      exp_bus.push_back(exp_ack ? 'h101 : 'h100);
      for (int i = 7; i >= 0; i--) wbit(d[i], i == gbit);
      rbit(b);
      obs_bus.push_back(b ? 'h100 : 'h101);
   endtask

   task automatic rbyte(input logic [7:0] exp_d, input logic ack);
      logic       b;
      logic [7:0] d;
      d = 8'd0;
      exp_bus.push_back(int'(exp_d));
      for (int i = 0; i < 8; i++) begin
         rbit(b);
         d = {d[6:0], b};
      end
      obs_bus.push_back(int'(d));
      wbit(~ack, 1'b0);
   endtask

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout, expected bench completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      repeat (3) @(negedge clk);
      for (int s = 0; s <= 6; s++) probe(s, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      q();

      // pointer write, repeated START, 4-byte read with final NACK
      i2c_start();
      wbyte(8'h66, 1'b1, -1);
      wbyte(8'h24, 1'b1, -1);
      wbyte(8'h00, 1'b1, -1);
      i2c_start();
      exp_rd.push_back(16'h2400);
      wbyte(8'h67, 1'b1, -1);
      rbyte(8'h12, 1'b1);
      exp_rd.push_back(16'h2401);
      rbyte(8'h34, 1'b1);
      rbyte(8'hAB, 1'b1);
      rbyte(8'hCD, 1'b0);
      probe(1, 32'd0);
      probe(2, 32'h2401);
      i2c_stop();

      // single word write
      i2c_start();
      exp_wr.push_back({16'h800D, 16'h1901});
      wbyte(8'h66, 1'b1, -1);
      wbyte(8'h80, 1'b1, -1);
      wbyte(8'h0D, 1'b1, -1);
      wbyte(8'h19, 1'b1, -1);
      probe(1, 32'd1);
      wbyte(8'h01, 1'b1, -1);
      i2c_stop();
      probe(2, 32'h800E);
      probe(1, 32'd0);

      // wrong address is never acknowledged
      quiet = 1'b1;
      i2c_start();
      wbyte(8'h64, 1'b0, -1);
      wbyte(8'h24, 1'b0, -1);
      i2c_stop();
      quiet = 1'b0;
      probe(7, 32'd0);
      probe(2, 32'h800E);

      // pointer wrap from FFFF to 0000
      i2c_start();
      wbyte(8'h66, 1'b1, -1);
      wbyte(8'hFF, 1'b1, -1);
      wbyte(8'hFF, 1'b1, -1);
      i2c_start();
      exp_rd.push_back(16'hFFFF);
      wbyte(8'h67, 1'b1, -1);
      rbyte(8'hBE, 1'b1);
      exp_rd.push_back(16'h0000);
      rbyte(8'hEF, 1'b1);
      rbyte(8'h5A, 1'b1);
      rbyte(8'h5A, 1'b0);
      i2c_stop();
      probe(2, 32'h0000);

      // SCL glitches while idle and inside bytes
      @(negedge clk);
      scl_drv = 1'b0;
      repeat (2) @(negedge clk);
      scl_drv = 1'b1;
      q();
      probe(1, 32'd0);
      i2c_start();
      exp_wr.push_back({16'h1234, 16'h5678});
      wbyte(8'h66, 1'b1, 5);
      wbyte(8'h12, 1'b1, 3);
      wbyte(8'h34, 1'b1, -1);
      wbyte(8'h56, 1'b1, 0);
      wbyte(8'h78, 1'b1, -1);
      i2c_stop();
      probe(2, 32'h1235);

      // reset while the target is driving a read bit
      i2c_start();
      wbyte(8'h66, 1'b1, -1);
      wbyte(8'h00, 1'b1, -1);
      wbyte(8'h10, 1'b1, -1);
      i2c_start();
      exp_rd.push_back(16'h0010);
      wbyte(8'h67, 1'b1, -1);
      probe(0, 32'd1);
      @(negedge clk);
      reset = 1'b1;
      probe(0, 32'd0);
      probe(1, 32'd0);
      probe(2, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      sda_drv = 1'b1;
      scl_drv = 1'b1;
      q(); q();

      i2c_start();
      exp_wr.push_back({16'h0020, 16'hCAFE});
      wbyte(8'h66, 1'b1, -1);
      wbyte(8'h00, 1'b1, -1);
      wbyte(8'h20, 1'b1, -1);
      wbyte(8'hCA, 1'b1, -1);
      wbyte(8'hFE, 1'b1, -1);
      i2c_stop();
      i2c_start();
      wbyte(8'h66, 1'b1, -1);
      wbyte(8'h00, 1'b1, -1);
      wbyte(8'h20, 1'b1, -1);
      i2c_start();
      exp_rd.push_back(16'h0020);
      wbyte(8'h67, 1'b1, -1);
      rbyte(8'hC3, 1'b0);
      i2c_stop();
      probe(1, 32'd0);
      probe(0, 32'd0);

      repeat (4) @(negedge clk);
      probe(8, 32'd0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
